// File: rtl/systolic_output_packer_if.sv
// Bus bundle for the systolic output packer.
// Upstream: element stream from the array (valid/yumi).
// Downstream: packed words toward writeback (valid/ready).
// Signal suffixes are named from the packer's point of view.
interface systolic_output_packer_if #(
   parameter int width_p = 8,
   parameter int pack_p  = 8
);
   localparam int cnt_w_lp = $clog2(pack_p + 1);

   logic                      valid_i;
   logic [width_p-1:0]        data_i;
   logic                      yumi_o;
   logic                      valid_o;
   logic                      ready_i;
   logic [pack_p*width_p-1:0] data_o;
   logic [cnt_w_lp-1:0]       count_o;
   logic                      last_o;

   modport slave (
      input  valid_i, data_i, ready_i,
      output yumi_o, valid_o, data_o, count_o, last_o
   );

   modport master (
      output valid_i, data_i, ready_i,
      input  yumi_o, valid_o, data_o, count_o, last_o
   );
endinterface

// File: rtl/systolic_output_packer.sv
// Packs pack_p serial result elements into one wide word and buffers the
// packed words in a small circular FIFO for the writeback side.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_PACK | normal operation: accept elements, push full or flushed words
// ST_PEND | flush requested while FIFO full; inputs blocked until push
module systolic_output_packer #(
   parameter int width_p    = 8,
   parameter int pack_p     = 8,
   parameter int fifo_els_p = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic                   flush_i,
   systolic_output_packer_if.slave bus,
   output logic                   busy_o,
   output logic                   idle_o
);
   localparam int lane_w_lp = $clog2(pack_p);
   localparam int cnt_w_lp  = $clog2(pack_p + 1);
   localparam int ptr_w_lp  = $clog2(fifo_els_p);
   localparam int used_w_lp = $clog2(fifo_els_p + 1);
   localparam int word_w_lp = pack_p * width_p;

   typedef enum logic {
      ST_PACK = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [lane_w_lp-1:0]   lane_q, lane_d;
   logic [word_w_lp-1:0]   pack_q, pack_d;
   logic [ptr_w_lp-1:0]    wr_ptr_q, wr_ptr_d;
   logic [ptr_w_lp-1:0]    rd_ptr_q, rd_ptr_d;
   logic [used_w_lp-1:0]   used_q, used_d;

   logic [word_w_lp-1:0]   mem_data_q [fifo_els_p];
   logic [cnt_w_lp-1:0]    mem_cnt_q  [fifo_els_p];
   logic                   mem_last_q [fifo_els_p];

   logic                   fifo_full, fifo_empty, last_lane;
   logic                   accept, push, pop;
   logic [word_w_lp-1:0]   fill_word;
   logic [cnt_w_lp-1:0]    push_cnt;
   logic                   push_last;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign fifo_full  = (used_q == used_w_lp'(fifo_els_p));
   assign fifo_empty = (used_q == '0);
   assign last_lane  = (lane_q == lane_w_lp'(pack_p - 1));

   // Reset is folded in so the array never sees a consume while we are held.
   assign accept = reset_i & en_i & bus.valid_i & (state_q == ST_PACK)
                 & (~last_lane | ~fifo_full);
   assign pop    = en_i & ~fifo_empty & bus.ready_i;

   assign bus.yumi_o = accept;

   // Packing register with the incoming element merged into the current lane.
   always_comb begin
      fill_word = pack_q;
      for (int k = 0; k < pack_p; k++) begin
         if (accept && (lane_q == lane_w_lp'(k))) begin
            fill_word[k*width_p +: width_p] = bus.data_i;
         end
      end
   end

   // Next state: lane bookkeeping, flush handling and push decision.
   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      pack_d    = pack_q;
      push      = 1'b0;
      push_cnt  = '0;
      push_last = 1'b0;
      if (en_i) begin
         unique case (state_q)
            ST_PACK: begin
               if (accept && last_lane) begin
                  // accept at the last lane is only allowed with FIFO room
                  push      = 1'b1;
                  push_cnt  = cnt_w_lp'(pack_p);
                  push_last = flush_i;
                  lane_d    = '0;
                  pack_d    = '0;
               end else if (accept) begin
                  if (flush_i && !fifo_full) begin
                     push      = 1'b1;
                     push_cnt  = cnt_w_lp'(lane_q) + cnt_w_lp'(1);
                     push_last = 1'b1;
                     lane_d    = '0;
                     pack_d    = '0;
                  end else begin
                     // element kept; a blocked flush waits with it included
                     lane_d = lane_q + lane_w_lp'(1);
                     pack_d = fill_word;
                     if (flush_i) begin
                        state_d = ST_PEND;
                     end
                  end
               end else if (flush_i && (lane_q != '0)) begin
                  if (!fifo_full) begin
                     push      = 1'b1;
                     push_cnt  = cnt_w_lp'(lane_q);
                     push_last = 1'b1;
                     lane_d    = '0;
                     pack_d    = '0;
                  end else begin
                     state_d = ST_PEND;
                  end
               end
            end
            ST_PEND: begin
               if (!fifo_full) begin
                  push      = 1'b1;
                  push_cnt  = cnt_w_lp'(lane_q);
                  push_last = 1'b1;
                  lane_d    = '0;
                  pack_d    = '0;
                  state_d   = ST_PACK;
               end
            end
         endcase
      end
   end

   // FIFO pointer and occupancy update.
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      used_d   = used_q;
      case ({push, pop})
         2'b10:   used_d = used_q + used_w_lp'(1);
         2'b01:   used_d = used_q - used_w_lp'(1);
         default: used_d = used_q;
      endcase
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= ST_PACK;
         lane_q   <= '0;
         pack_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         used_q   <= '0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         pack_q   <= pack_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         used_q   <= used_d;
      end
   end

   // FIFO storage; contents are don't-care until the pointers cover them.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= fill_word;
         mem_cnt_q[wr_ptr_q]  <= push_cnt;
         mem_last_q[wr_ptr_q] <= push_last;
      end
   end

   assign bus.valid_o = ~fifo_empty;
   assign bus.data_o  = fifo_empty ? '0   : mem_data_q[rd_ptr_q];
   assign bus.count_o = fifo_empty ? '0   : mem_cnt_q[rd_ptr_q];
   assign bus.last_o  = fifo_empty ? 1'b0 : mem_last_q[rd_ptr_q];

   assign busy_o = (lane_q != '0) | (state_q == ST_PEND) | ~fifo_empty;
   assign idle_o = ~busy_o;
endmodule

// File: tb/tb_systolic_output_packer.sv
// Bench for systolic_output_packer: directed scenarios plus a randomized
// run, all checked cycle by cycle against a queue-based behavioural model.
module tb_systolic_output_packer;
   localparam int W  = 8;
   localparam int P  = 8;
   localparam int E  = 4;
   localparam int CW = $clog2(P + 1);

   logic clk = 1'b0;
   logic rst_n, en, flush;
   logic busy, idle;

   always #5 clk = ~clk;

   systolic_output_packer_if #(.width_p(W), .pack_p(P)) bus ();

   systolic_output_packer #(.width_p(W), .pack_p(P), .fifo_els_p(E)) dut (
      .clk_i   (clk),
      .reset_i (rst_n),
      .en_i    (en),
      .flush_i (flush),
      .bus     (bus),
      .busy_o  (busy),
      .idle_o  (idle)
   );

   typedef struct {
      logic [P*W-1:0] data;
      int             cnt;
      bit             last;
   } word_t;

   word_t          m_fifo[$];
   word_t          seen[$];
   logic [W-1:0]   m_part[$];
   bit             m_pend;
   int             tests = 0;
   int             fails = 0;
   int             acc_cnt = 0;

   task automatic close_word(input bit last);
      word_t w;
      w.data = '0;
      for (int k = 0; k < m_part.size(); k++) w.data[k*W +: W] = m_part[k];
      w.cnt  = m_part.size();
      w.last = last;
      m_fifo.push_back(w);
      m_part.delete();
   endtask

   task automatic model_clear();
      m_fifo.delete();
      m_part.delete();
      m_pend = 1'b0;
   endtask

   // One clock: drive, check outputs against the model, advance the model.
   task automatic step(input bit v, input logic [W-1:0] d, input bit f,
                       input bit r, input bit e);
      bit    full_pre, exp_yumi, exp_valid, exp_idle;
      word_t hw, got;
      bus.valid_i = v;
      bus.data_i  = d;
      flush       = f;
      bus.ready_i = r;
      en          = e;
      #1;
      full_pre  = (m_fifo.size() == E);
      exp_yumi  = e & v & ~m_pend & ((m_part.size() != P - 1) | ~full_pre);
      exp_valid = (m_fifo.size() > 0);
      exp_idle  = !((m_part.size() > 0) || m_pend || (m_fifo.size() > 0));
      tests++;
      if (bus.yumi_o !== exp_yumi) begin
         fails++;
         $display("FAIL yumi @%0t: got %b expected %b", $time, bus.yumi_o, exp_yumi);
      end
      tests++;
      if (bus.valid_o !== exp_valid) begin
         fails++;
         $display("FAIL valid @%0t: got %b expected %b", $time, bus.valid_o, exp_valid);
      end
      tests++;
      if (idle !== exp_idle || busy !== !exp_idle) begin
         fails++;
         $display("FAIL idle @%0t: got idle=%b busy=%b expected idle=%b", $time, idle, busy, exp_idle);
      end
      if (exp_valid) begin
         hw = m_fifo[0];
         tests++;
         if ({bus.data_o, bus.count_o, bus.last_o} !== {hw.data, CW'(hw.cnt), hw.last}) begin
            fails++;
            $display("FAIL head @%0t: got %h/%0d/%b expected %h/%0d/%b", $time,
                     bus.data_o, bus.count_o, bus.last_o, hw.data, hw.cnt, hw.last);
         end
      end else begin
         tests++;
         if ({bus.data_o, bus.count_o, bus.last_o} !== '0) begin
            fails++;
            $display("FAIL idle_out @%0t: got %h/%0d/%b expected zeros", $time,
                     bus.data_o, bus.count_o, bus.last_o);
         end
      end
      if (bus.valid_o === 1'b1 && r && e) begin
         got.data = bus.data_o;
         got.cnt  = int'(bus.count_o);
         got.last = bus.last_o;
         seen.push_back(got);
      end
      if (bus.yumi_o === 1'b1) acc_cnt++;
      if (e) begin
         if (exp_valid && r) void'(m_fifo.pop_front());
         if (exp_yumi) m_part.push_back(d);
         if (m_pend) begin
            if (!full_pre) begin
               close_word(1'b1);
               m_pend = 1'b0;
            end
         end else if (exp_yumi && m_part.size() == P) begin
            close_word(f);
         end else if (f && m_part.size() > 0) begin
            if (!full_pre) close_word(1'b1);
            else m_pend = 1'b1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic pulse_reset(input int n);
      rst_n       = 1'b0;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b1;
      en          = 1'b1;
      flush       = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         #1;
         tests++;
         if (bus.yumi_o !== 1'b0 || bus.valid_o !== 1'b0 || idle !== 1'b1) begin
            fails++;
            $display("FAIL reset cyc%0d: got yumi=%b valid=%b idle=%b expected 0/0/1",
                     i, bus.yumi_o, bus.valid_o, idle);
         end
      end
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      pulse_reset(3);
   endtask

   task automatic test_full_rate();
      seen.delete();
      acc_cnt = 0;
      for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b1);
      idle_steps(2);
      tests++;
      if (acc_cnt != 16 || seen.size() != 2) begin
         fails++;
         $display("FAIL full_rate_count: got acc=%0d words=%0d expected 16/2", acc_cnt, seen.size());
      end else begin
         tests++;
         if ({seen[0].data, seen[0].cnt, seen[0].last} !== {64'h0807060504030201, 8, 1'b0}) begin
            fails++;
            $display("FAIL full_rate_w0: got %h/%0d/%b expected 0807060504030201/8/0",
                     seen[0].data, seen[0].cnt, seen[0].last);
         end
         tests++;
         if ({seen[1].data, seen[1].cnt, seen[1].last} !== {64'h100F0E0D0C0B0A09, 8, 1'b0}) begin
            fails++;
            $display("FAIL full_rate_w1: got %h/%0d/%b expected 100F0E0D0C0B0A09/8/0",
                     seen[1].data, seen[1].cnt, seen[1].last);
         end
      end
   endtask

   task automatic test_partial_flush();
      seen.delete();
      step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
      step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1);
      step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      idle_steps(3);
      tests++;
      if (seen.size() != 1) begin
         fails++;
         $display("FAIL partial_count: got %0d words expected 1", seen.size());
      end else begin
         tests++;
         if ({seen[0].data, seen[0].cnt, seen[0].last} !== {64'h0000000000CCBBAA, 3, 1'b1}) begin
            fails++;
            $display("FAIL partial_word: got %h/%0d/%b expected 0000000000CCBBAA/3/1",
                     seen[0].data, seen[0].cnt, seen[0].last);
         end
      end
      step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      idle_steps(3);
      tests++;
      if (seen.size() != 1) begin
         fails++;
         $display("FAIL empty_flush: got %0d words expected 1", seen.size());
      end
   endtask

   task automatic test_flush_accept();
      seen.delete();
      for (int i = 0; i < 7; i++) step(1'b1, W'(8'h11 + i), 1'b0, 1'b1, 1'b1);
      step(1'b1, 8'h18, 1'b1, 1'b1, 1'b1);
      idle_steps(3);
      tests++;
      if (seen.size() != 1) begin
         fails++;
         $display("FAIL flush_acc_count: got %0d words expected 1", seen.size());
      end else begin
         tests++;
         if ({seen[0].data, seen[0].cnt, seen[0].last} !== {64'h1817161514131211, 8, 1'b1}) begin
            fails++;
            $display("FAIL flush_acc_word: got %h/%0d/%b expected 1817161514131211/8/1",
                     seen[0].data, seen[0].cnt, seen[0].last);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [P*W-1:0] exp_d;
      int             exp_c;
      seen.delete();
      acc_cnt = 0;
      for (int i = 0; i < 40; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b1);
      tests++;
      if (acc_cnt != 39) begin
         fails++;
         $display("FAIL bp_accepts: got %0d expected 39", acc_cnt);
      end
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tests++;
      if (seen.size() != 0) begin
         fails++;
         $display("FAIL bp_freeze: got %0d pops expected 0", seen.size());
      end
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      idle_steps(8);
      tests++;
      if (seen.size() != 5) begin
         fails++;
         $display("FAIL bp_drain_count: got %0d words expected 5", seen.size());
      end else begin
         for (int j = 0; j < 5; j++) begin
            exp_d = '0;
            exp_c = (j < 4) ? 8 : 7;
            for (int k = 0; k < exp_c; k++) exp_d[k*W +: W] = W'(8*j + k + 1);
            tests++;
            if ({seen[j].data, seen[j].cnt, seen[j].last} !== {exp_d, exp_c, (j == 4)}) begin
               fails++;
               $display("FAIL bp_word%0d: got %h/%0d/%b expected %h/%0d/%b", j,
                        seen[j].data, seen[j].cnt, seen[j].last, exp_d, exp_c, (j == 4));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      seen.delete();
      for (int i = 0; i < 13; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b1);
      pulse_reset(1);
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      idle_steps(3);
      tests++;
      if (seen.size() != 0) begin
         fails++;
         $display("FAIL reset_mid: got %0d words after reset expected 0", seen.size());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 9) < 7), W'($urandom),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) != 0));
      end
      step(1'b0, '0, 1'b1, 1'b1, 1'b1);
      idle_steps(8);
      tests++;
      if (idle !== 1'b1 || m_fifo.size() != 0) begin
         fails++;
         $display("FAIL random_drain: got idle=%b model_words=%0d expected 1/0", idle, m_fifo.size());
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      en          = 1'b1;
      flush       = 1'b0;
      bus.valid_i = 1'b1;
      bus.data_i  = '0;
      bus.ready_i = 1'b0;
      model_clear();
      test_reset();
      test_full_rate();
      test_partial_flush();
      test_flush_accept();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
